range_filter: RTL and testbench

//  Downstream consumer of the ultrasonic ping driver's distance word. Validates

---
 rtl/range_filter.sv | 151 +++++++++++++++
 tb/tb_range_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/range_filter.sv
// Range filter: validates ping-driver distance words, averages the last 2**LOG2_DEPTH
// good samples and classifies the mean into CLEAR / CAUTION / STOP with hysteresis.
// Latency: avg_valid pulses on the edge after the sample edge; reports STOP until primed.
module range_filter #(
  parameter int WIDTH        = 16,
  parameter int LOG2_DEPTH   = 2,
  parameter int STOP_MM      = 300,
  parameter int CAUTION_MM   = 800,
  parameter int HYST_MM      = 50,
  parameter int MAX_RANGE_MM = 4000,
  parameter int MISS_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meas_done,
  input  logic [WIDTH-1:0] distance,
  output logic [WIDTH-1:0] avg_distance,
  output logic             avg_valid,
  output logic [1:0]       zone,
  output logic             no_echo
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam int MW    = $clog2(MISS_LIMIT + 1);

  localparam logic [WIDTH-1:0] MAX_T       = WIDTH'(MAX_RANGE_MM);
  localparam logic [WIDTH-1:0] STOP_T      = WIDTH'(STOP_MM);
  localparam logic [WIDTH-1:0] CAUTION_T   = WIDTH'(CAUTION_MM);
  localparam logic [WIDTH-1:0] STOP_REL    = WIDTH'(STOP_MM + HYST_MM);
  localparam logic [WIDTH-1:0] CAUTION_REL = WIDTH'(CAUTION_MM + HYST_MM);
  localparam logic [LOG2_DEPTH:0] FULL     = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [MW-1:0] MISS_MAX       = MW'(MISS_LIMIT);
  localparam logic [MW-1:0] MISS_LAST      = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    Z_CLEAR   = 2'b00,
    Z_CAUTION = 2'b01,
    Z_STOP    = 2'b10
  } zone_t;

  logic [WIDTH-1:0]      buf_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH:0]   fill;
  logic [SW-1:0]         sum;
  logic [MW-1:0]         miss_cnt;
  logic                  upd_pend;
  logic                  flush_pend;
  zone_t                 zone_q;
  zone_t                 zone_next;

  logic                  accept;
  logic                  miss;
  logic                  flush_now;
  logic                  primed;
  logic [WIDTH-1:0]      slot_old;
  logic [WIDTH-1:0]      avg_new;

  // Sample qualification; the slot being overwritten only leaves the sum once the window is full.
  always_comb begin
    accept    = meas_done && (distance != '0) && (distance <= MAX_T);
    miss      = meas_done && !accept;
    flush_now = miss && (miss_cnt == MISS_LAST);
    primed    = (fill == FULL);
    slot_old  = primed ? buf_q[wr_ptr] : '0;
    avg_new   = sum[SW-1:LOG2_DEPTH];
  end

  // Zone transition for a fresh average; release points sit HYST_MM above the entry points.
  always_comb begin
    zone_next = Z_STOP;
    case (zone_q)
      Z_CLEAR: begin
        if (avg_new < STOP_T)         zone_next = Z_STOP;
        else if (avg_new < CAUTION_T) zone_next = Z_CAUTION;
        else                          zone_next = Z_CLEAR;
      end
      Z_CAUTION: begin
        if (avg_new < STOP_T)            zone_next = Z_STOP;
        else if (avg_new >= CAUTION_REL) zone_next = Z_CLEAR;
        else                             zone_next = Z_CAUTION;
      end
      Z_STOP: begin
        if (avg_new >= CAUTION_REL)   zone_next = Z_CLEAR;
        else if (avg_new >= STOP_REL) zone_next = Z_CAUTION;
        else                          zone_next = Z_STOP;
      end
      default: zone_next = Z_STOP;
    endcase
  end

  // Window bookkeeping: ring buffer, running sum, fill level and miss counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sum        <= '0;
      miss_cnt   <= '0;
      upd_pend   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      upd_pend   <= accept;
      flush_pend <= flush_now;
      if (accept) begin
        buf_q[wr_ptr] <= distance;
        wr_ptr        <= wr_ptr + 1'b1;
        sum           <= sum + SW'(distance) - SW'(slot_old);
        if (!primed) fill <= fill + 1'b1;
        miss_cnt      <= '0;
      end else if (flush_now) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        wr_ptr   <= '0;
        fill     <= '0;
        sum      <= '0;
        miss_cnt <= MISS_MAX;
      end else if (miss && (miss_cnt < MISS_MAX)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  // Registered outputs and zone FSM; a flush forces CLEAR and emits a zero-average pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_distance <= '0;
      avg_valid    <= 1'b0;
      zone_q       <= Z_STOP;
      no_echo      <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (!(zone_q inside {Z_CLEAR, Z_CAUTION, Z_STOP})) zone_q <= Z_STOP;
      if (upd_pend && primed) begin
        avg_distance <= avg_new;
        avg_valid    <= 1'b1;
        zone_q       <= zone_next;
      end else if (flush_pend) begin
        avg_distance <= '0;
        avg_valid    <= 1'b1;
      end
      if (accept) no_echo <= 1'b0;
      if (flush_now) begin
        no_echo <= 1'b1;
        zone_q  <= Z_CLEAR;
      end
    end
  end

  assign zone = zone_q;

endmodule

// File: tb/tb_range_filter.sv
// Bench for range_filter: directed scenarios plus random strobes, compared each cycle
// against a queue-based model of the windowed mean, miss counting and zone rules.
module tb_range_filter;

  localparam int DEPTH   = 4;
  localparam int STOP    = 300;
  localparam int CAUTION = 800;
  localparam int HYST    = 50;
  localparam int MAXR    = 4000;
  localparam int MISSL   = 3;

  logic        clk;
  logic        reset;
  logic        meas_done;
  logic [15:0] distance;
  logic [15:0] avg_distance;
  logic        avg_valid;
  logic [1:0]  zone;
  logic        no_echo;

  int checks = 0;
  int errors = 0;

  // model state
  int win[$];
  int m_misses;
  int m_avg, m_valid, m_zone, m_no_echo;
  int m_upd, m_upd_avg, m_flush;

  range_filter dut (
    .clk          (clk),
    .reset        (reset),
    .meas_done    (meas_done),
    .distance     (distance),
    .avg_distance (avg_distance),
    .avg_valid    (avg_valid),
    .zone         (zone),
    .no_echo      (no_echo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Zone decision: entering a more cautious zone uses the plain thresholds,
  // leaving it requires clearing threshold + hysteresis.
  function automatic int zone_rule(input int z, input int a);
    if (z == 2) begin
      if (a >= CAUTION + HYST) return 0;
      if (a >= STOP + HYST)    return 1;
      return 2;
    end
    if (a < STOP) return 2;
    if (z == 1) return (a >= CAUTION + HYST) ? 0 : 1;
    return (a < CAUTION) ? 1 : 0;
  endfunction

  function automatic int win_mean();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / DEPTH;
  endfunction

  task automatic model_reset();
    win.delete();
    m_misses = 0; m_avg = 0; m_valid = 0; m_zone = 2; m_no_echo = 0;
    m_upd = 0; m_upd_avg = 0; m_flush = 0;
  endtask

  task automatic model_edge(input bit md, input int d);
    m_valid = 0;
    if (m_upd != 0) begin
      m_avg = m_upd_avg; m_valid = 1; m_zone = zone_rule(m_zone, m_upd_avg);
    end else if (m_flush != 0) begin
      m_avg = 0; m_valid = 1;
    end
    m_upd = 0; m_flush = 0;
    if (md) begin
      if (d > 0 && d <= MAXR) begin
        win.push_back(d);
        if (win.size() > DEPTH) void'(win.pop_front());
        m_misses = 0; m_no_echo = 0;
        if (win.size() == DEPTH) begin m_upd = 1; m_upd_avg = win_mean(); end
      end else if (m_misses < MISSL) begin
        m_misses++;
        if (m_misses == MISSL) begin
          win.delete(); m_no_echo = 1; m_zone = 0; m_flush = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("avg_valid", int'(avg_valid), m_valid);
    chk("avg_distance", int'(avg_distance), m_avg);
    chk("zone", int'(zone), m_zone);
    chk("no_echo", int'(no_echo), m_no_echo);
  endtask

  task automatic step(input bit md, input int d);
    int dv;
    dv = d;
    meas_done = md;
    distance  = dv[15:0];
    @(posedge clk);
    model_edge(md, d);
    @(negedge clk);
    meas_done = 1'b0;
    compare_all();
  endtask

  task automatic sample(input int d);
    step(1'b1, d);
    step(1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    meas_done = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    int r, c, d;
    reset = 1'b1; meas_done = 1'b0; distance = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // priming: three samples give nothing, fourth pulses two cycles after its strobe
    repeat (3) sample(1000);
    chk("prime_zone_stop", int'(zone), 2);
    step(1'b1, 1000);
    chk("prime_no_early_pulse", int'(avg_valid), 0);
    step(1'b0, 0);
    chk("prime_pulse", int'(avg_valid), 1);
    chk("prime_avg", int'(avg_distance), 1000);
    chk("prime_zone_clear", int'(zone), 0);

    // descending averages 800/600/400/200
    repeat (4) sample(200);
    chk("desc_zone_stop", int'(zone), 2);
    chk("desc_avg", int'(avg_distance), 200);

    // hysteresis climb
    repeat (6) sample(330);
    chk("hyst_still_stop", int'(zone), 2);
    repeat (8) sample(900);
    chk("hyst_clear", int'(zone), 0);

    // no_echo after three misses, then re-priming
    sample(0); sample(5000); step(1'b1, 0);
    chk("noecho_set", int'(no_echo), 1);
    step(1'b0, 0);
    chk("flush_pulse_avg", int'(avg_distance), 0);
    repeat (3) sample(500);
    chk("noecho_clear", int'(no_echo), 0);
    sample(500);

    // back-to-back strobes
    for (int i = 1; i <= 4; i++) step(1'b1, i * 100);
    step(1'b0, 0);
    chk("b2b_avg", int'(avg_distance), 250);
    step(1'b1, 1); step(1'b1, 1); step(1'b1, 1); step(1'b1, 2);
    step(1'b0, 0);
    chk("trunc_avg", int'(avg_distance), 1);

    // range edges
    sample(4000); sample(4001); sample(4000);

    // reset between strobe and its pulse
    repeat (3) sample(1000);
    step(1'b1, 1000);
    reset = 1'b1;
    model_reset();
    #2;
    chk("midrst_valid", int'(avg_valid), 0);
    chk("midrst_zone", int'(zone), 2);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    step(1'b0, 0);
    step(1'b0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        c = $urandom_range(0, 11);
        if (c == 0)      d = 0;
        else if (c == 1) d = $urandom_range(4001, 65535);
        else if (c < 5)  d = $urandom_range(250, 400);
        else if (c < 8)  d = $urandom_range(750, 900);
        else             d = $urandom_range(1, 4000);
        step(1'b1, d);
      end else begin
        step(1'b0, 0);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
